pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/sat_counter.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 109 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Hazard control shared types: FSM state enum, register-address width,
// zero-register constant and the load-use detect helper.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    FLUSH      = 2'd3
  } hz_state_e;

  function automatic logic load_use_f(
    input logic                  mem_read,
    input logic [REG_ADDR_W-1:0] ex_rt,
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rt,
    input logic                  uses_rt
  );
    return mem_read && (ex_rt != ZERO_REG) &&
           ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clock, inc (count enable), clear (sync, wins over inc), count.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (clear)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory freeze.
// Ports: clock, reset_n (sync, active-low), ID/EX hazard fields, pipe enables/flushes, state, stall_cycles.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_uses_rt,
  input  logic                   ex_mem_read,
  input  logic [4:0]             ex_rt,
  input  logic                   branch_taken,
  input  logic                   mem_busy,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic [1:0]             state,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam logic [3:0] FC_RELOAD = 4'(FLUSH_CYCLES - 1);

  hz_state_e  cur_st;
  hz_state_e  nxt_st;
  logic [3:0] fcnt;
  logic [3:0] fcnt_nxt;
  logic       load_use;

  assign load_use = load_use_f(ex_mem_read, ex_rt,
                               id_rs, id_rt, id_uses_rt);
  assign state = cur_st;

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    nxt_st      = RUN;
    fcnt_nxt    = fcnt;
    if (!reset_n) begin
      // Bubble both pipeline registers on the reset edge.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      fcnt_nxt    = '0;
    end else begin
      unique case (cur_st)
        FLUSH: begin
          if (mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            nxt_st      = FLUSH;
          end else begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (fcnt != 4'd0)
              fcnt_nxt = fcnt - 4'd1;
            // Last flush cycle is the one that drains fcnt to zero.
            nxt_st = (fcnt > 4'd1) ? FLUSH : RUN;
          end
        end
        RUN, LOAD_STALL, MEM_WAIT: begin
          if (mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            nxt_st      = MEM_WAIT;
          end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            fcnt_nxt    = FC_RELOAD;
            nxt_st      = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
          end else if (load_use && (cur_st != LOAD_STALL)) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            nxt_st      = LOAD_STALL;
          end
        end
        default: nxt_st = RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cur_st <= RUN;
      fcnt   <= '0;
    end else begin
      cur_st <= nxt_st;
      fcnt   <= fcnt_nxt;
    end
  end

  sat_counter #(
    .WIDTH(STALL_CNT_W)
  ) u_stall_cnt (
    .clock(clock),
    .inc  (reset_n & ~pc_write),
    .clear(~reset_n),
    .count(stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (FLUSH_CYCLES=3).
// Directed table, counter saturation run and randomized model comparison.
module tb_pipeline_hazard_ctrl;

  localparam int FC = 3;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_mem_read, branch_taken, mem_busy;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic [1:0]  state;
  logic [15:0] stall_cycles;

  int n_vec = 0;
  int n_bad = 0;

  // behavioural model state
  int m_flush_left;
  bit m_stalled;
  bit m_waiting;
  int m_cnt;

  typedef struct {
    bit         rst_n;
    bit         mem_read;
    bit [4:0]   ext;
    bit [4:0]   rs;
    bit [4:0]   rt;
    bit         uses_rt;
    bit         br;
    bit         busy;
    bit [3:0]   e_out;
    bit [15:0]  e_stall;
  } vec_t;

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES(FC),
    .STALL_CNT_W (16)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .branch_taken(branch_taken),
    .mem_busy    (mem_busy),
    .pc_write    (pc_write),
    .if_id_write (if_id_write),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .state       (state),
    .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  // Drive one cycle: compare pre-edge outputs to the model (and to the
  // table entry when chk_tab), then advance the model on the edge.
  task automatic apply(input vec_t v, input bit chk_tab);
    bit        lu;
    bit [3:0]  e_o;
    bit [1:0]  e_s;
    bit [21:0] exp_all, got_all;
    reset_n      = v.rst_n;
    ex_mem_read  = v.mem_read;
    ex_rt        = v.ext;
    id_rs        = v.rs;
    id_rt        = v.rt;
    id_uses_rt   = v.uses_rt;
    branch_taken = v.br;
    mem_busy     = v.busy;
    #1;
    lu = v.mem_read && v.ext != 0 &&
         (v.ext == v.rs || (v.uses_rt && v.ext == v.rt));
    if (m_flush_left > 0)  e_s = 2'd3;
    else if (m_waiting)    e_s = 2'd2;
    else if (m_stalled)    e_s = 2'd1;
    else                   e_s = 2'd0;
    if (!v.rst_n)                 e_o = 4'b0011;
    else if (v.busy)              e_o = 4'b0000;
    else if (m_flush_left > 0)    e_o = 4'b1111;
    else if (v.br)                e_o = 4'b1111;
    else if (lu && !m_stalled)    e_o = 4'b0001;
    else                          e_o = 4'b1100;
    exp_all = {e_o, e_s, 16'(m_cnt)};
    got_all = {pc_write, if_id_write, if_id_flush, id_ex_flush,
               state, stall_cycles};
    n_vec++;
    if (got_all !== exp_all) begin
      n_bad++;
      $display("FAIL model t=%0t got out=%b st=%0d cnt=%0d exp out=%b st=%0d cnt=%0d",
               $time, got_all[21:18], got_all[17:16], got_all[15:0],
               e_o, e_s, m_cnt);
    end
    if (chk_tab) begin
      n_vec++;
      if ({pc_write, if_id_write, if_id_flush, id_ex_flush, stall_cycles}
          !== {v.e_out, v.e_stall}) begin
        n_bad++;
        $display("FAIL table t=%0t got out=%b cnt=%0d exp out=%b cnt=%0d",
                 $time, {pc_write, if_id_write, if_id_flush, id_ex_flush},
                 stall_cycles, v.e_out, v.e_stall);
      end
    end
    @(posedge clock);
    if (!v.rst_n) begin
      m_flush_left = 0; m_stalled = 0; m_waiting = 0; m_cnt = 0;
    end else begin
      if (!e_o[3] && m_cnt < 65535) m_cnt++;
      if (v.busy) begin
        m_stalled = 0;
        m_waiting = (m_flush_left == 0);
      end else if (m_flush_left > 0) begin
        m_flush_left--;
        m_stalled = 0; m_waiting = 0;
      end else if (v.br) begin
        m_flush_left = FC - 1;
        m_stalled = 0; m_waiting = 0;
      end else if (lu && !m_stalled) begin
        m_stalled = 1; m_waiting = 0;
      end else begin
        m_stalled = 0; m_waiting = 0;
      end
    end
    @(negedge clock);
  endtask

  function automatic vec_t mk(bit r, bit mr, int ext, int rs, int rt,
                              bit u, bit br, bit bz, bit [3:0] eo,
                              int es);
    vec_t v;
    v.rst_n = r; v.mem_read = mr; v.ext = 5'(ext); v.rs = 5'(rs);
    v.rt = 5'(rt); v.uses_rt = u; v.br = br; v.busy = bz;
    v.e_out = eo; v.e_stall = 16'(es);
    return v;
  endfunction

  vec_t tab[$];
  vec_t rv;

  initial begin
    reset_n = 0; ex_mem_read = 0; ex_rt = 0; id_rs = 0; id_rt = 0;
    id_uses_rt = 0; branch_taken = 0; mem_busy = 0;
    m_flush_left = 0; m_stalled = 0; m_waiting = 0; m_cnt = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);

    //          rst mr ex rs rt u br bz  out      cnt
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 0));
    tab.push_back(mk(1, 1, 5, 5, 0, 0, 0, 0, 4'b0001, 0));
    tab.push_back(mk(1, 1, 5, 5, 0, 0, 0, 0, 4'b1100, 1));
    tab.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 4'b1100, 1));
    tab.push_back(mk(1, 1, 7, 3, 7, 0, 0, 0, 4'b1100, 1));
    tab.push_back(mk(1, 1, 7, 3, 7, 1, 0, 0, 4'b0001, 1));
    tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 2));
    tab.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 2));
    tab.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 2));
    tab.push_back(mk(1, 1, 4, 4, 0, 0, 0, 0, 4'b1111, 2));
    tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 2));
    tab.push_back(mk(1, 1, 9, 9, 0, 0, 0, 1, 4'b0000, 2));
    tab.push_back(mk(1, 1, 9, 9, 0, 0, 0, 1, 4'b0000, 3));
    tab.push_back(mk(1, 1, 9, 9, 0, 0, 0, 1, 4'b0000, 4));
    tab.push_back(mk(1, 1, 9, 9, 0, 0, 0, 1, 4'b0000, 5));
    tab.push_back(mk(1, 1, 9, 9, 0, 0, 0, 0, 4'b0001, 6));
    tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 7));
    tab.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 7));
    tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 7));
    tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 8));
    tab.push_back(mk(0, 1, 2, 2, 0, 0, 1, 1, 4'b0011, 8));
    tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 0));
    foreach (tab[i]) apply(tab[i], 1'b1);

    // Hold the pipe frozen long enough to saturate the counter.
    rv = mk(1, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 0);
    for (int i = 0; i < 65536 + 3; i++) apply(rv, 1'b0);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 16'hFFFF), 1'b1);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 16'hFFFF), 1'b1);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 0), 1'b1);

    for (int i = 0; i < 3000; i++) begin
      rv = mk(($urandom_range(0, 49) != 0),
              $urandom_range(0, 1),
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 1),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 7) == 0), 4'b0000, 0);
      apply(rv, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
